// File: rtl/video_arb_pkg.sv
// Shared types and constants for the two-input video stream packet arbiter.
// The optional ARB_STATS_EN macro affects only video_stream_arbiter.
package video_arb_pkg;

    localparam int unsigned DEFAULT_BITWIDTH  = 32;
    localparam int unsigned DEFAULT_CNT_WIDTH = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_0    = 2'b01;
    localparam logic [1:0] GNT_1    = 2'b10;

    // Input index owning a one-hot grant (0 for GNT_0, 1 for GNT_1)
    function automatic logic gnt_owner(input logic [1:0] gnt);
        return gnt[1];
    endfunction

endpackage

// File: rtl/video_st_reg_slice.sv
// Single-stage Avalon-ST register slice carrying data/sop/eop/valid.
// Accepts a new beat whenever the held beat is empty or being consumed.
module video_st_reg_slice
    import video_arb_pkg::*;
#(
    parameter int unsigned BITWIDTH = DEFAULT_BITWIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BITWIDTH-1:0] in_data,
    input  logic                in_valid,
    input  logic                in_sop,
    input  logic                in_eop,
    output logic                slice_free,
    output logic [BITWIDTH-1:0] out_data,
    output logic                out_valid,
    output logic                out_sop,
    output logic                out_eop,
    input  logic                out_ready
);

    logic [BITWIDTH-1:0] data_r;
    logic                valid_r;
    logic                sop_r;
    logic                eop_r;

    assign slice_free = ~valid_r | out_ready;
    assign out_data   = data_r;
    assign out_valid  = valid_r;
    assign out_sop    = sop_r;
    assign out_eop    = eop_r;

    // Output beat register; holds its contents while stalled downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r  <= {BITWIDTH{1'b0}};
            valid_r <= 1'b0;
            sop_r   <= 1'b0;
            eop_r   <= 1'b0;
        end else if (slice_free) begin
            valid_r <= in_valid;
            if (in_valid) begin
                data_r <= in_data;
                sop_r  <= in_sop;
                eop_r  <= in_eop;
            end else begin
                sop_r  <= 1'b0;
                eop_r  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/video_stream_arbiter.sv
// Two-input round-robin packet arbiter merging SOP/EOP framed video streams.
// Define ARB_STATS_EN to add the per-input completed-packet counters.
module video_stream_arbiter
    import video_arb_pkg::*;
#(
    parameter int unsigned BITWIDTH  = DEFAULT_BITWIDTH,
    parameter int unsigned CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BITWIDTH-1:0]  sink0_data,
    input  logic                 sink0_valid,
    input  logic                 sink0_sop,
    input  logic                 sink0_eop,
    output logic                 sink0_ready,
    input  logic [BITWIDTH-1:0]  sink1_data,
    input  logic                 sink1_valid,
    input  logic                 sink1_sop,
    input  logic                 sink1_eop,
    output logic                 sink1_ready,
    output logic [BITWIDTH-1:0]  source_data,
    output logic                 source_valid,
    output logic                 source_sop,
    output logic                 source_eop,
    input  logic                 source_ready,
    output logic [1:0]           grant,
    output logic                 drop_pulse
`ifdef ARB_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] pkt_cnt0,
    output logic [CNT_WIDTH-1:0] pkt_cnt1
`endif
);

    arb_state_e          state_r;
    arb_state_e          state_s;
    logic [1:0]          grant_r;
    logic [1:0]          grant_s;
    logic                last_r;
    logic                last_s;
    logic                drop_r;
    logic                drop_s;
    logic                slice_free_s;
    logic                cand0_s;
    logic                cand1_s;
    logic                orphan0_s;
    logic                orphan1_s;
    logic                sel_s;
    logic                fwd_valid_s;
    logic                fwd_sop_s;
    logic                fwd_eop_s;
    logic [BITWIDTH-1:0] fwd_data_s;
    logic                acc_s;

    assign grant       = grant_r;
    assign drop_pulse  = drop_r;
    assign sink0_ready = (state_r == ST_LOCK) ? (slice_free_s & ~sel_s)
                       : (slice_free_s & ((fwd_valid_s & ~sel_s) | orphan0_s));
    assign sink1_ready = (state_r == ST_LOCK) ? (slice_free_s & sel_s)
                       : (slice_free_s & ((fwd_valid_s & sel_s) | orphan1_s));

    // State register: FSM state, grant, last-served pointer and drop pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            grant_r <= GNT_NONE;
            last_r  <= 1'b1;
            drop_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
            last_r  <= last_s;
            drop_r  <= drop_s;
        end
    end

    // Output comb: pick the serving input, orphan discards and the beat offered to the slice
    always_comb begin
        cand0_s   = sink0_valid & sink0_sop;
        cand1_s   = sink1_valid & sink1_sop;
        orphan0_s = 1'b0;
        orphan1_s = 1'b0;
        sel_s     = 1'b0;
        fwd_valid_s = 1'b0;
        drop_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                orphan0_s = sink0_valid & ~sink0_sop;
                orphan1_s = sink1_valid & ~sink1_sop;
                if (cand0_s && cand1_s) begin
                    fwd_valid_s = 1'b1;
                    sel_s       = ~last_r;
                end else if (cand0_s) begin
                    fwd_valid_s = 1'b1;
                    sel_s       = 1'b0;
                end else if (cand1_s) begin
                    fwd_valid_s = 1'b1;
                    sel_s       = 1'b1;
                end else begin
                    fwd_valid_s = 1'b0;
                    sel_s       = 1'b0;
                end
                drop_s = slice_free_s & (orphan0_s | orphan1_s);
            end
            ST_LOCK: begin
                sel_s       = gnt_owner(grant_r);
                fwd_valid_s = sel_s ? sink1_valid : sink0_valid;
                drop_s      = 1'b0;
            end
            default: begin
                sel_s       = 1'b0;
                fwd_valid_s = 1'b0;
                drop_s      = 1'b0;
            end
        endcase
        fwd_data_s = sel_s ? sink1_data : sink0_data;
        fwd_sop_s  = sel_s ? sink1_sop  : sink0_sop;
        fwd_eop_s  = sel_s ? sink1_eop  : sink0_eop;
        acc_s      = fwd_valid_s & slice_free_s;
    end

    // Next-state comb: lock on a multi-beat SOP, release on the accepted EOP
    always_comb begin
        state_s = state_r;
        grant_s = grant_r;
        last_s  = last_r;
        case (state_r)
            ST_IDLE: begin
                if (acc_s) begin
                    last_s = sel_s;
                    if (!fwd_eop_s) begin
                        state_s = ST_LOCK;
                        grant_s = sel_s ? GNT_1 : GNT_0;
                    end else begin
                        state_s = ST_IDLE;
                        grant_s = GNT_NONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                    grant_s = GNT_NONE;
                end
            end
            ST_LOCK: begin
                if (acc_s && fwd_eop_s) begin
                    state_s = ST_IDLE;
                    grant_s = GNT_NONE;
                end else begin
                    state_s = ST_LOCK;
                    grant_s = grant_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                grant_s = GNT_NONE;
            end
        endcase
    end

    video_st_reg_slice #(
        .BITWIDTH (BITWIDTH)
    ) u_slice (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (fwd_data_s),
        .in_valid   (fwd_valid_s),
        .in_sop     (fwd_sop_s),
        .in_eop     (fwd_eop_s),
        .slice_free (slice_free_s),
        .out_data   (source_data),
        .out_valid  (source_valid),
        .out_sop    (source_sop),
        .out_eop    (source_eop),
        .out_ready  (source_ready)
    );

`ifdef ARB_STATS_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] cnt0_r;
    logic [CNT_WIDTH-1:0] cnt1_r;

    assign pkt_cnt0 = cnt0_r;
    assign pkt_cnt1 = cnt1_r;

    // Completed-packet counters, bumped on each accepted EOP of the serving input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_r <= {CNT_WIDTH{1'b0}};
            cnt1_r <= {CNT_WIDTH{1'b0}};
        end else if (acc_s && fwd_eop_s) begin
            if (sel_s) begin
                cnt1_r <= cnt1_r + CNT_ONE;
            end else begin
                cnt0_r <= cnt0_r + CNT_ONE;
            end
        end
    end
`else
    if (CNT_WIDTH == 0) begin : g_cnt_width_check
        $error("CNT_WIDTH must be non-zero");
    end
`endif

endmodule

// File: tb/tb_video_stream_arbiter.sv
// Directed self-checking bench for video_stream_arbiter.
// Counter checks are compiled in only when ARB_STATS_EN is defined.
module tb_video_stream_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] sink0_data, sink1_data, source_data;
    logic        sink0_valid, sink0_sop, sink0_eop, sink0_ready;
    logic        sink1_valid, sink1_sop, sink1_eop, sink1_ready;
    logic        source_valid, source_sop, source_eop, source_ready;
    logic [1:0]  grant;
    logic        drop_pulse;
`ifdef ARB_STATS_EN
    logic [15:0] pkt_cnt0, pkt_cnt1;
`endif
    logic [34:0] out_w;
    int          checks = 0;
    int          errors = 0;

    assign out_w = {source_valid, source_sop, source_eop, source_data};

    always #5 clk = ~clk;

    video_stream_arbiter #(.BITWIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .sink0_data(sink0_data), .sink0_valid(sink0_valid), .sink0_sop(sink0_sop),
        .sink0_eop(sink0_eop), .sink0_ready(sink0_ready),
        .sink1_data(sink1_data), .sink1_valid(sink1_valid), .sink1_sop(sink1_sop),
        .sink1_eop(sink1_eop), .sink1_ready(sink1_ready),
        .source_data(source_data), .source_valid(source_valid), .source_sop(source_sop),
        .source_eop(source_eop), .source_ready(source_ready),
        .grant(grant), .drop_pulse(drop_pulse)
`ifdef ARB_STATS_EN
        , .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic s, input logic e, input logic [31:0] d);
        sink0_valid = v; sink0_sop = s; sink0_eop = e; sink0_data = d;
    endtask

    task automatic drive1(input logic v, input logic s, input logic e, input logic [31:0] d);
        sink1_valid = v; sink1_sop = s; sink1_eop = e; sink1_data = d;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        drive0(1'b0, 1'b0, 1'b0, 32'h0);
        drive1(1'b0, 1'b0, 1'b0, 32'h0);
        source_ready = 1'b1;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        drive0(1'b0, 1'b0, 1'b0, 32'h0);
        drive1(1'b0, 1'b0, 1'b0, 32'h0);
        source_ready = 1'b1;
        tick;
        tick;
        if (out_w !== 35'h0) begin errors++; $display("FAIL reset_out got %h expected %h", out_w, 35'h0); end
        checks++;
        if ({grant, drop_pulse} !== 3'b000) begin errors++; $display("FAIL reset_grant_drop got %b expected %b", {grant, drop_pulse}, 3'b000); end
        checks++;
`ifdef ARB_STATS_EN
        if ({pkt_cnt0, pkt_cnt1} !== 32'h0) begin errors++; $display("FAIL reset_cnt got %h expected %h", {pkt_cnt0, pkt_cnt1}, 32'h0); end
        checks++;
`endif
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_single_source;
        logic [34:0] exp_v;
        logic [1:0]  exp_g;
        do_reset;
        for (int i = 0; i < 4; i++) begin
            drive0(1'b1, (i == 0), (i == 3), 32'h0000_0A00 + 32'(i));
            #1;
            if (sink0_ready !== 1'b1) begin errors++; $display("FAIL single_ready%0d got %b expected %b", i, sink0_ready, 1'b1); end
            checks++;
            tick;
            exp_v = {1'b1, (i == 0), (i == 3), 32'h0000_0A00 + 32'(i)};
            exp_g = (i == 3) ? 2'b00 : 2'b01;
            if (out_w !== exp_v) begin errors++; $display("FAIL single_out%0d got %h expected %h", i, out_w, exp_v); end
            checks++;
            if (grant !== exp_g) begin errors++; $display("FAIL single_grant%0d got %b expected %b", i, grant, exp_g); end
            checks++;
        end
        drive0(1'b0, 1'b0, 1'b0, 32'h0);
        tick;
        if ({source_valid, grant} !== 3'b000) begin errors++; $display("FAIL single_idle got %b expected %b", {source_valid, grant}, 3'b000); end
        checks++;
    endtask

    task automatic test_arbitration;
        logic [34:0] exp_v;
        logic [1:0]  exp_r;
        logic [1:0]  exp_g;
        do_reset;
        for (int k = 0; k < 6; k++) begin
            if (k < 3) drive0(1'b1, (k == 0), (k == 2), 32'h0000_0A00 + 32'(k));
            else       drive0(1'b0, 1'b0, 1'b0, 32'h0);
            if (k < 3) drive1(1'b1, 1'b1, 1'b0, 32'h0000_0B00);
            else       drive1(1'b1, (k == 3), (k == 5), 32'h0000_0B00 + 32'(k - 3));
            #1;
            exp_r = (k < 3) ? 2'b10 : 2'b01;
            if ({sink0_ready, sink1_ready} !== exp_r) begin errors++; $display("FAIL arb_ready%0d got %b expected %b", k, {sink0_ready, sink1_ready}, exp_r); end
            checks++;
            tick;
            exp_v = {1'b1, (k == 0 || k == 3), (k == 2 || k == 5),
                     (k < 3) ? 32'h0000_0A00 + 32'(k) : 32'h0000_0B00 + 32'(k - 3)};
            exp_g = (k < 2) ? 2'b01 : ((k == 3 || k == 4) ? 2'b10 : 2'b00);
            if (out_w !== exp_v) begin errors++; $display("FAIL arb_out%0d got %h expected %h", k, out_w, exp_v); end
            checks++;
            if (grant !== exp_g) begin errors++; $display("FAIL arb_grant%0d got %b expected %b", k, grant, exp_g); end
            checks++;
        end
        drive0(1'b0, 1'b0, 1'b0, 32'h0);
        drive1(1'b0, 1'b0, 1'b0, 32'h0);
        tick;
    endtask

    task automatic test_back_to_back;
        logic [34:0] exp_v;
        logic [1:0]  exp_r;
        do_reset;
        for (int k = 0; k < 4; k++) begin
            if ((k + 1) / 2 < 2) drive0(1'b1, 1'b1, 1'b1, 32'h0000_0C00 + 32'((k + 1) / 2));
            else                 drive0(1'b0, 1'b0, 1'b0, 32'h0);
            drive1(1'b1, 1'b1, 1'b1, 32'h0000_0D00 + 32'(k / 2));
            #1;
            exp_r = (k % 2 == 0) ? 2'b10 : 2'b01;
            if ({sink0_ready, sink1_ready} !== exp_r) begin errors++; $display("FAIL b2b_ready%0d got %b expected %b", k, {sink0_ready, sink1_ready}, exp_r); end
            checks++;
            tick;
            exp_v = {3'b111, (k % 2 == 0) ? 32'h0000_0C00 + 32'(k / 2) : 32'h0000_0D00 + 32'(k / 2)};
            if (out_w !== exp_v) begin errors++; $display("FAIL b2b_out%0d got %h expected %h", k, out_w, exp_v); end
            checks++;
            if (grant !== 2'b00) begin errors++; $display("FAIL b2b_grant%0d got %b expected %b", k, grant, 2'b00); end
            checks++;
        end
        drive0(1'b0, 1'b0, 1'b0, 32'h0);
        drive1(1'b0, 1'b0, 1'b0, 32'h0);
        tick;
`ifdef ARB_STATS_EN
        if ({pkt_cnt0, pkt_cnt1} !== {16'd2, 16'd2}) begin errors++; $display("FAIL b2b_cnt got %h expected %h", {pkt_cnt0, pkt_cnt1}, {16'd2, 16'd2}); end
        checks++;
`endif
    endtask

    task automatic test_stall;
        int   idx_t[6] = '{0, 1, 2, 2, 2, 3};
        int   out_t[6] = '{0, 1, 1, 1, 2, 3};
        logic sr_t[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [34:0] exp_v;
        do_reset;
        for (int k = 0; k < 6; k++) begin
            drive0(1'b1, (idx_t[k] == 0), (idx_t[k] == 3), 32'h0000_0E00 + 32'(idx_t[k]));
            source_ready = sr_t[k];
            #1;
            if (sink0_ready !== sr_t[k]) begin errors++; $display("FAIL stall_ready%0d got %b expected %b", k, sink0_ready, sr_t[k]); end
            checks++;
            tick;
            exp_v = {1'b1, (out_t[k] == 0), (out_t[k] == 3), 32'h0000_0E00 + 32'(out_t[k])};
            if (out_w !== exp_v) begin errors++; $display("FAIL stall_out%0d got %h expected %h", k, out_w, exp_v); end
            checks++;
            if (grant !== ((k == 5) ? 2'b00 : 2'b01)) begin errors++; $display("FAIL stall_grant%0d got %b", k, grant); end
            checks++;
        end
        drive0(1'b0, 1'b0, 1'b0, 32'h0);
        source_ready = 1'b1;
        tick;
        if (source_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got %b expected %b", source_valid, 1'b0); end
        checks++;
    endtask

    task automatic test_orphan;
        do_reset;
        drive1(1'b1, 1'b0, 1'b1, 32'h0000_DEAD);
        #1;
        if (sink1_ready !== 1'b1) begin errors++; $display("FAIL orphan_ready got %b expected %b", sink1_ready, 1'b1); end
        checks++;
        tick;
        if ({drop_pulse, source_valid} !== 2'b10) begin errors++; $display("FAIL orphan_drop got %b expected %b", {drop_pulse, source_valid}, 2'b10); end
        checks++;
        drive1(1'b0, 1'b0, 1'b0, 32'h0);
        tick;
        if (drop_pulse !== 1'b0) begin errors++; $display("FAIL orphan_pulse_end got %b expected %b", drop_pulse, 1'b0); end
        checks++;
        drive0(1'b1, 1'b0, 1'b0, 32'h0000_1111);
        drive1(1'b1, 1'b0, 1'b0, 32'h0000_2222);
        #1;
        if ({sink0_ready, sink1_ready} !== 2'b11) begin errors++; $display("FAIL orphan2_ready got %b expected %b", {sink0_ready, sink1_ready}, 2'b11); end
        checks++;
        tick;
        if ({drop_pulse, source_valid} !== 2'b10) begin errors++; $display("FAIL orphan2_drop got %b expected %b", {drop_pulse, source_valid}, 2'b10); end
        checks++;
        drive0(1'b0, 1'b0, 1'b0, 32'h0);
        drive1(1'b0, 1'b0, 1'b0, 32'h0);
        tick;
        if (drop_pulse !== 1'b0) begin errors++; $display("FAIL orphan2_pulse_end got %b expected %b", drop_pulse, 1'b0); end
        checks++;
`ifdef ARB_STATS_EN
        if ({pkt_cnt0, pkt_cnt1} !== 32'h0) begin errors++; $display("FAIL orphan_cnt got %h expected %h", {pkt_cnt0, pkt_cnt1}, 32'h0); end
        checks++;
`endif
    endtask

    task automatic test_reset_in_lock;
        do_reset;
        drive0(1'b1, 1'b1, 1'b0, 32'h0000_F000);
        tick;
        drive0(1'b1, 1'b0, 1'b0, 32'h0000_F001);
        tick;
        if (grant !== 2'b01) begin errors++; $display("FAIL rlock_grant got %b expected %b", grant, 2'b01); end
        checks++;
        #2;
        rst_n = 1'b0;
        #1;
        if (out_w !== 35'h0) begin errors++; $display("FAIL rlock_out got %h expected %h", out_w, 35'h0); end
        checks++;
        if ({grant, drop_pulse} !== 3'b000) begin errors++; $display("FAIL rlock_grant_drop got %b expected %b", {grant, drop_pulse}, 3'b000); end
        checks++;
`ifdef ARB_STATS_EN
        if ({pkt_cnt0, pkt_cnt1} !== 32'h0) begin errors++; $display("FAIL rlock_cnt got %h expected %h", {pkt_cnt0, pkt_cnt1}, 32'h0); end
        checks++;
`endif
        #2;
        rst_n = 1'b1;
        drive0(1'b1, 1'b1, 1'b1, 32'h0000_6000);
        drive1(1'b1, 1'b1, 1'b1, 32'h0000_6001);
        #1;
        if ({sink0_ready, sink1_ready} !== 2'b10) begin errors++; $display("FAIL rlock_ready got %b expected %b", {sink0_ready, sink1_ready}, 2'b10); end
        checks++;
        tick;
        if (out_w !== {3'b111, 32'h0000_6000}) begin errors++; $display("FAIL rlock_first got %h expected %h", out_w, {3'b111, 32'h0000_6000}); end
        checks++;
        drive0(1'b0, 1'b0, 1'b0, 32'h0);
        drive1(1'b0, 1'b0, 1'b0, 32'h0);
        tick;
    endtask

    initial begin
        test_reset;
        test_single_source;
        test_arbitration;
        test_back_to_back;
        test_stall;
        test_orphan;
        test_reset_in_lock;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_stream_arbiter.md
Name: video_stream_arbiter

Overview:
- Two-input packet-level arbiter. It merges two Avalon-ST video streams (SOP/EOP framed, for example the outputs of two video-in packet FIFOs) onto one downstream stream.
- Grant is decided per packet using round-robin. The granted input owns the output from its accepted SOP beat to its accepted EOP beat.
- Output is driven from a single register slice.
- Sits between the input packet buffers and the shared video processing core.

Parameters:
- BITWIDTH, 32, data width per beat.
- CNT_WIDTH, 16, width of the per-source packet counters (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- sink0_data  in  BITWIDTH  input 0 data.
- sink0_valid  in  1  input 0 valid.
- sink0_sop  in  1  input 0 start of packet.
- sink0_eop  in  1  input 0 end of packet.
- sink0_ready  out  1  input 0 ready.
- sink1_data / sink1_valid / sink1_sop / sink1_eop / sink1_ready  same widths and meanings as input 0, for input 1.
- source_data  out  BITWIDTH  output data.
- source_valid  out  1  output valid.
- source_sop  out  1  output start of packet.
- source_eop  out  1  output end of packet.
- source_ready  in  1  downstream ready.
- grant  out  2  one-hot owner of the current packet; 00 when idle.
- drop_pulse  out  1  one-cycle pulse when an orphan beat is discarded.
- pkt_cnt0, pkt_cnt1  out  CNT_WIDTH each  completed packets per input; present only with ARB_STATS_EN.

Behaviour:
- Reset: async on rst_n low; all registers clear.
  - source_valid/sop/eop = 0, source_data = 0, grant = 00, drop_pulse = 0, last-served pointer = 1 (so input 0 wins first), counters = 0.
- Output slice:
  - slice_free = !source_valid | source_ready.
  - A beat accepted from a sink is registered into the source_* outputs on the same edge. Latency is 1 cycle.
  - source_* outputs hold stable while source_valid=1 and source_ready=0.
- State machine IDLE / LOCK:
  - IDLE, candidates: an input with valid & sop. Both candidates → the input not last-served wins. One candidate → it wins.
  - IDLE, sink ready: sinkX_ready = slice_free for the winner. A non-winner whose valid=1 and sop=1 gets ready=0 and waits.
  - IDLE, winner accepted with eop=0: go to LOCK, set grant to the winner, update last-served to the winner.
  - IDLE, winner accepted with eop=1 (single-beat packet): stay in IDLE, update last-served; grant stays 00.
  - LOCK: only the granted input sees ready = slice_free; the other input's ready = 0.
  - LOCK → IDLE on the accepted beat with eop=1; grant returns to 00 on the same edge.
  - LOCK, granted input asserts sop again before eop (truncated packet): treat it as a new packet. Forward the beat, keep the grant, no error.
  - LOCK, granted input deasserts valid: grant is held indefinitely; no timeout.
- Orphan beats:
  - In IDLE, a beat with valid=1 and sop=0 on an input that is not the winner is accepted (ready=1) and discarded.
  - drop_pulse=1 for that cycle. Both inputs with orphan beats in the same cycle → both discarded, one pulse.
- Same cycle as eop: the final beat is accepted and the FSM returns to IDLE. A competing sop is evaluated in the following cycle, not the current one, giving one idle arbitration cycle per packet boundary.
- The arbiter never accepts a beat when slice_free=0.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - pkt_cnt0/pkt_cnt1 exist.
  - Each increments by 1 on every accepted eop beat from its input, including single-beat packets.
  - Wraps modulo 2^CNT_WIDTH; cleared by reset.
  - Dropped orphan beats are not counted.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package video_arb_pkg holds:
  - state enum {ST_IDLE, ST_LOCK};
  - grant encodings GNT_NONE=2'b00, GNT_0=2'b01, GNT_1=2'b10;
  - default BITWIDTH.
- One sub-module: video_st_reg_slice, the output register slice with data/sop/eop/valid and ready handling.

Test Plan:
- Reset, then only input 0 sends a 4-beat packet (sop on beat 1, eop on beat 4) with source_ready=1 → output shows the same 4 beats 1 cycle later; grant=01 during beats 2-4; grant=00 after eop.
- Both inputs present sop at the same cycle, 3-beat packets each → input 0 packet fully out first, then input 1; sink1_ready=0 throughout input 0's packet.
- Four back-to-back single-beat packets (sop=eop=1) on both inputs continuously → output order 0,1,0,1; grant stays 00.
- source_ready toggles 1,0,0,1 mid-packet → no beat lost or duplicated; source_data held while stalled.
- In IDLE, input 1 sends valid=1 sop=0 data=0xDEAD → beat not forwarded; drop_pulse high for 1 cycle.
- rst_n pulsed low while in LOCK mid-packet → all outputs 0 immediately; next sop from either input is arbitrated with input 0 preferred. With ARB_STATS_EN, pkt_cnt0/pkt_cnt1 read 0 after reset.
